// File: rtl/cs_sched_38_if.sv
// cs_sched_38_if -- request/decoder bundle for the cs_sched_38 arbiter.
//   req          : per-requester request vector (into the arbiter)
//   A2, A1, A0   : decoder address, A2 is the MSB
//   E1_n, E2_n   : active-low decoder enables
//   E3           : active-high decoder enable
//   gnt_n        : active-low one-hot grant (decode of {A2,A1,A0})
//   busy         : arbiter is not idle
interface cs_sched_38_if;
  logic [7:0] req;
  logic       A2;
  logic       A1;
  logic       A0;
  logic       E1_n;
  logic       E2_n;
  logic       E3;
  logic [7:0] gnt_n;
  logic       busy;

  modport master (
    output req,
    input  A2, A1, A0, E1_n, E2_n, E3, gnt_n, busy
  );

  modport slave (
    input  req,
    output A2, A1, A0, E1_n, E2_n, E3, gnt_n, busy
  );
endinterface

// File: rtl/cs_sched_38.sv
// cs_sched_38 -- round-robin arbiter driving a shared 3-to-8 decoded select.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cs_sched_38_if.slave (req in; A2..A0, E1_n, E2_n, E3, gnt_n, busy out)
// Parameters:
//   HOLD   : maximum grant length in cycles (1..15)
//   GAP_EN : 1 = one dead cycle between grants, 0 = back-to-back grants
//
// state | meaning
// IDLE  | no grant, decoder disabled, address holds last winner
// GRANT | decoder enabled for the current winner, cnt counts grant cycles
// GAP   | one dead cycle after a grant, then re-arbitrate
module cs_sched_38 #(
  parameter int HOLD   = 4,
  parameter int GAP_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  cs_sched_38_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  logic [1:0] state_q, state_nxt;
  logic [2:0] ptr_q, ptr_nxt;
  logic [3:0] cnt_q, cnt_nxt;
  logic [2:0] addr_q, addr_nxt;
  logic       e1_n_q, e2_n_q, e3_q;
  logic [7:0] gnt_n_q;

  logic       win_vld;
  logic [2:0] win_idx;
  logic [2:0] scan_idx;

  // Round-robin scan starting just after the last winner; a sole requester
  // wraps around to itself on the eighth step.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = ptr_q;
    scan_idx = ptr_q;
    for (int k = 1; k <= 8; k++) begin
      scan_idx = ptr_q + 3'(k);
      if (!win_vld && bus.req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    cnt_nxt   = cnt_q;
    addr_nxt  = addr_q;
    case (state_q)
      IDLE, GAP: begin
        if (win_vld) begin
          state_nxt = GRANT;
          addr_nxt  = win_idx;
          ptr_nxt   = win_idx;
          cnt_nxt   = 4'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        cnt_nxt = cnt_q + 4'd1;
        // Only the current winner's request matters here (early release).
        if (cnt_q == HOLD_M1 || !bus.req[addr_q]) begin
          cnt_nxt = 4'd0;
          if (GAP_EN != 0) begin
            state_nxt = GAP;
          end else if (win_vld) begin
            state_nxt = GRANT;
            addr_nxt  = win_idx;
            ptr_nxt   = win_idx;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Decoder outputs are registered from the next state so they line up with
  // the state register: enables and grant change on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd7;
      cnt_q   <= 4'd0;
      addr_q  <= 3'd0;
      e1_n_q  <= 1'b1;
      e2_n_q  <= 1'b1;
      e3_q    <= 1'b0;
      gnt_n_q <= 8'hFF;
    end else begin
      state_q <= state_nxt;
      ptr_q   <= ptr_nxt;
      cnt_q   <= cnt_nxt;
      addr_q  <= addr_nxt;
      e1_n_q  <= (state_nxt != GRANT);
      e2_n_q  <= (state_nxt != GRANT);
      e3_q    <= (state_nxt == GRANT);
      gnt_n_q <= (state_nxt == GRANT) ? ~(8'h01 << addr_nxt) : 8'hFF;
    end
  end

  assign bus.A2    = addr_q[2];
  assign bus.A1    = addr_q[1];
  assign bus.A0    = addr_q[0];
  assign bus.E1_n  = e1_n_q;
  assign bus.E2_n  = e2_n_q;
  assign bus.E3    = e3_q;
  assign bus.gnt_n = gnt_n_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_cs_sched_38.sv
// tb_cs_sched_38 -- self-checking bench for cs_sched_38.
// Four instances cover HOLD=4/GAP_EN=1 (a), HOLD=4/GAP_EN=0 (b),
// HOLD=8/GAP_EN=1 (c) and HOLD=1/GAP_EN=1 (d). Expected per-cycle outputs
// come from hand-derived vector tables pushed to a scoreboard queue.
module tb_cs_sched_38;

  logic clk;
  logic rst_n;

  cs_sched_38_if if_a ();
  cs_sched_38_if if_b ();
  cs_sched_38_if if_c ();
  cs_sched_38_if if_d ();

  cs_sched_38 #(.HOLD(4), .GAP_EN(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  cs_sched_38 #(.HOLD(4), .GAP_EN(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  cs_sched_38 #(.HOLD(8), .GAP_EN(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  cs_sched_38 #(.HOLD(1), .GAP_EN(1)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt_n;
    logic       busy;
    logic [2:0] addr;
  } vec_t;

  vec_t vq[$];
  vec_t sb[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] o_gnt;
  logic       o_busy, o_e1, o_e2, o_e3;
  logic [2:0] o_addr;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input int d, input logic [7:0] r);
    if_a.req = (d == 0) ? r : 8'h00;
    if_b.req = (d == 1) ? r : 8'h00;
    if_c.req = (d == 2) ? r : 8'h00;
    if_d.req = (d == 3) ? r : 8'h00;
  endtask

  task automatic sample(input int d);
    case (d)
      0: begin o_gnt = if_a.gnt_n; o_busy = if_a.busy; o_addr = {if_a.A2, if_a.A1, if_a.A0};
               o_e1 = if_a.E1_n; o_e2 = if_a.E2_n; o_e3 = if_a.E3; end
      1: begin o_gnt = if_b.gnt_n; o_busy = if_b.busy; o_addr = {if_b.A2, if_b.A1, if_b.A0};
               o_e1 = if_b.E1_n; o_e2 = if_b.E2_n; o_e3 = if_b.E3; end
      2: begin o_gnt = if_c.gnt_n; o_busy = if_c.busy; o_addr = {if_c.A2, if_c.A1, if_c.A0};
               o_e1 = if_c.E1_n; o_e2 = if_c.E2_n; o_e3 = if_c.E3; end
      default: begin o_gnt = if_d.gnt_n; o_busy = if_d.busy; o_addr = {if_d.A2, if_d.A1, if_d.A0};
               o_e1 = if_d.E1_n; o_e2 = if_d.E2_n; o_e3 = if_d.E3; end
    endcase
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    sample(d);
    check($sformatf("%s dut%0d gnt_n", tag, d), o_gnt, 8'hFF);
    check($sformatf("%s dut%0d busy", tag, d), {7'd0, o_busy}, 8'd0);
    check($sformatf("%s dut%0d addr", tag, d), {5'd0, o_addr}, 8'd0);
    check($sformatf("%s dut%0d enables", tag, d), {5'd0, o_e1, o_e2, o_e3}, 8'b110);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 8'h00);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) check_reset_outputs(d, "reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] g, input logic b, input logic [2:0] a);
    vec_t v;
    v.req = r; v.gnt_n = g; v.busy = b; v.addr = a;
    vq.push_back(v);
  endtask

  task automatic run_vectors(input int d, input string name);
    vec_t v, e;
    logic en;
    int   n;
    n = 0;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      @(negedge clk);
      drive(d, v.req);
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      sample(d);
      en = (e.gnt_n != 8'hFF);
      check($sformatf("%s[%0d] gnt_n", name, n), o_gnt, e.gnt_n);
      check($sformatf("%s[%0d] busy", name, n), {7'd0, o_busy}, {7'd0, e.busy});
      check($sformatf("%s[%0d] addr", name, n), {5'd0, o_addr}, {5'd0, e.addr});
      check($sformatf("%s[%0d] enables", name, n), {5'd0, o_e1, o_e2, o_e3}, {5'd0, !en, !en, en});
      check($sformatf("%s[%0d] onehot", name, n), {7'd0, ($countones(~o_gnt) <= 1)}, 8'd1);
      n++;
    end
  endtask

  initial begin
    logic [7:0] oh;
    rst_n = 1'b0;
    drive(0, 8'h00);

    do_reset();
    for (int i = 0; i < 10; i++) add(8'h00, 8'hFF, 1'b0, 3'd0);
    run_vectors(0, "idle");

    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) add(8'h01, 8'hFE, 1'b1, 3'd0);
      add(8'h01, 8'hFF, 1'b1, 3'd0);
    end
    add(8'h00, 8'hFF, 1'b0, 3'd0);
    run_vectors(0, "solo0");

    do_reset();
    for (int i = 0; i < 4; i++) add(8'h81, 8'hFE, 1'b1, 3'd0);
    add(8'h81, 8'hFF, 1'b1, 3'd0);
    for (int i = 0; i < 4; i++) add(8'h81, 8'h7F, 1'b1, 3'd7);
    add(8'h81, 8'hFF, 1'b1, 3'd7);
    for (int i = 0; i < 2; i++) add(8'h81, 8'hFE, 1'b1, 3'd0);
    run_vectors(0, "alt07");

    do_reset();
    add(8'h01, 8'hFE, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) add(8'h03, 8'hFE, 1'b1, 3'd0);
    add(8'h03, 8'hFF, 1'b1, 3'd0);
    add(8'h03, 8'hFD, 1'b1, 3'd1);
    run_vectors(0, "reqchg");

    do_reset();
    for (int w = 0; w < 9; w++) begin
      oh = 8'h01 << (w % 8);
      for (int i = 0; i < 4; i++) add(8'hFF, ~oh, 1'b1, 3'(w % 8));
    end
    add(8'h00, 8'hFF, 1'b0, 3'd0);
    run_vectors(1, "nogap");

    do_reset();
    add(8'h08, 8'hF7, 1'b1, 3'd3);
    add(8'h08, 8'hF7, 1'b1, 3'd3);
    add(8'h00, 8'hFF, 1'b1, 3'd3);
    add(8'h00, 8'hFF, 1'b0, 3'd3);
    add(8'h00, 8'hFF, 1'b0, 3'd3);
    run_vectors(2, "early");

    do_reset();
    add(8'h03, 8'hFE, 1'b1, 3'd0);
    add(8'h03, 8'hFF, 1'b1, 3'd0);
    add(8'h03, 8'hFD, 1'b1, 3'd1);
    add(8'h03, 8'hFF, 1'b1, 3'd1);
    add(8'h03, 8'hFE, 1'b1, 3'd0);
    run_vectors(3, "hold1");

    do_reset();
    for (int i = 0; i < 4; i++) add(8'h21, 8'hFE, 1'b1, 3'd0);
    add(8'h21, 8'hFF, 1'b1, 3'd0);
    for (int i = 0; i < 2; i++) add(8'h21, 8'hDF, 1'b1, 3'd5);
    run_vectors(0, "abort");
    // Mid-cycle reset during the grant to index 5; no clock edge in between.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "async");
    @(negedge clk);
    rst_n = 1'b1;
    add(8'h21, 8'hFE, 1'b1, 3'd0);
    add(8'h21, 8'hFE, 1'b1, 3'd0);
    run_vectors(0, "after_abort");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
